// File: rtl/fabric2_resp_router.sv
// Slave-facing router of the fabric v2 decoder: forwards one OCP command to the decoded port
// and returns that port's response, or a local ERR for unpopulated ports.
// Optional watchdog: define FABRIC2_RESP_TIMEOUT_EN to answer ERR after TIMEOUT cycles in CMD/RESP.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE 3'b000
`endif
`ifndef OCP_CMD_WRITE
`define OCP_CMD_WRITE 3'b001
`endif
`ifndef OCP_CMD_READ
`define OCP_CMD_READ 3'b010
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`endif
`ifndef OCP_RESP_DVA
`define OCP_RESP_DVA 2'b01
`endif
`ifndef OCP_RESP_ERR
`define OCP_RESP_ERR 2'b11
`endif

module fabric2_resp_router #(
    parameter int unsigned PORTNO_WIDTH = 11,
    parameter int unsigned NPORTS       = 4
`ifdef FABRIC2_RESP_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT      = 255
`endif
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PORTNO_WIDTH-1:0]         i_portno,
    input  logic [`ADDR_WIDTH-1:0]          i_addr,
    input  logic [2:0]                      i_MCmd,
    input  logic [`DATA_WIDTH-1:0]          i_MData,
    input  logic [`BEN_WIDTH-1:0]           i_MByteEn,
    output logic                            o_SCmdAccept,
    output logic [`DATA_WIDTH-1:0]          o_SData,
    output logic [1:0]                      o_SResp,
    output logic [NPORTS*`ADDR_WIDTH-1:0]   o_MAddr,
    output logic [NPORTS*3-1:0]             o_MCmd,
    output logic [NPORTS*`DATA_WIDTH-1:0]   o_MData,
    output logic [NPORTS*`BEN_WIDTH-1:0]    o_MByteEn,
    input  logic [NPORTS-1:0]               i_SCmdAccept,
    input  logic [NPORTS*`DATA_WIDTH-1:0]   i_SData,
    input  logic [NPORTS*2-1:0]             i_SResp
);

    localparam int unsigned AW  = `ADDR_WIDTH;
    localparam int unsigned DW  = `DATA_WIDTH;
    localparam int unsigned BW  = `BEN_WIDTH;
    localparam int unsigned CW  = 3;
    localparam int unsigned RW  = 2;
    localparam int unsigned PW1 = PORTNO_WIDTH + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    logic [1:0]              state, state_d;
    logic [PORTNO_WIDTH-1:0] port_q, port_d;
    logic [CW-1:0]           cmd_q, cmd_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [DW-1:0]           data_q, data_d;
    logic [BW-1:0]           ben_q, ben_d;

    logic [RW-1:0]           sresp_d;
    logic [DW-1:0]           sdata_d;
    logic [NPORTS*AW-1:0]    maddr_d;
    logic [NPORTS*CW-1:0]    mcmd_d;
    logic [NPORTS*DW-1:0]    mdata_d;
    logic [NPORTS*BW-1:0]    mben_d;

    logic                    sel_accept;
    logic [RW-1:0]           sel_resp;
    logic [DW-1:0]           sel_data;
    logic                    drive_cmd;
    logic                    timeout_hit;

    assign o_SCmdAccept = (state == ST_IDLE) && (i_MCmd != `OCP_CMD_IDLE);

    // Only the captured port's handshake signals are observed; all others are ignored.
    always_comb begin
        sel_accept = 1'b0;
        sel_resp   = `OCP_RESP_NULL;
        sel_data   = '0;
        for (int k = 0; k < int'(NPORTS); k++) begin
            if (port_q == PORTNO_WIDTH'(k)) begin
                sel_accept = i_SCmdAccept[k];
                sel_resp   = i_SResp[k*RW +: RW];
                sel_data   = i_SData[k*DW +: DW];
            end
        end
    end

`ifdef FABRIC2_RESP_TIMEOUT_EN
    localparam int unsigned TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TW-1:0] cnt, cnt_d;

    // Cleared while IDLE so it starts from zero on every CMD entry.
    always_comb begin
        cnt_d       = (state == ST_CMD || state == ST_RESP) ? cnt + TW'(1) : '0;
        timeout_hit = (cnt >= TW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        port_d    = port_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        ben_d     = ben_q;
        sresp_d   = `OCP_RESP_NULL;
        sdata_d   = '0;
        drive_cmd = 1'b0;
        case (state)
            ST_IDLE: begin
                if (o_SCmdAccept) begin
                    port_d = i_portno;
                    cmd_d  = i_MCmd;
                    addr_d = i_addr;
                    data_d = i_MData;
                    ben_d  = i_MByteEn;
                    // Full-width compare so out-of-range port numbers never alias a real port.
                    if (PW1'(i_portno) < PW1'(NPORTS)) begin
                        state_d   = ST_CMD;
                        drive_cmd = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        sresp_d = `OCP_RESP_ERR;
                    end
                end
            end
            ST_CMD: begin
                if (sel_accept) begin
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    sresp_d = `OCP_RESP_ERR;
                end else begin
                    drive_cmd = 1'b1;
                end
            end
            ST_RESP: begin
                if (sel_resp != `OCP_RESP_NULL) begin
                    state_d = ST_IDLE;
                    sresp_d = sel_resp;
                    sdata_d = sel_data;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    sresp_d = `OCP_RESP_ERR;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Slave-side buses: the captured command appears on one slice, everything else is idle/zero.
    always_comb begin
        mcmd_d  = {NPORTS{`OCP_CMD_IDLE}};
        maddr_d = '0;
        mdata_d = '0;
        mben_d  = '0;
        for (int k = 0; k < int'(NPORTS); k++) begin
            if (drive_cmd && (port_d == PORTNO_WIDTH'(k))) begin
                mcmd_d[k*CW +: CW]  = cmd_d;
                maddr_d[k*AW +: AW] = addr_d;
                mdata_d[k*DW +: DW] = data_d;
                mben_d[k*BW +: BW]  = ben_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_q <= '0;
            cmd_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            ben_q  <= '0;
        end else begin
            port_q <= port_d;
            cmd_q  <= cmd_d;
            addr_q <= addr_d;
            data_q <= data_d;
            ben_q  <= ben_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_SResp   <= `OCP_RESP_NULL;
            o_SData   <= '0;
            o_MCmd    <= {NPORTS{`OCP_CMD_IDLE}};
            o_MAddr   <= '0;
            o_MData   <= '0;
            o_MByteEn <= '0;
        end else begin
            o_SResp   <= sresp_d;
            o_SData   <= sdata_d;
            o_MCmd    <= mcmd_d;
            o_MAddr   <= maddr_d;
            o_MData   <= mdata_d;
            o_MByteEn <= mben_d;
        end
    end

endmodule

// File: tb/tb_fabric2_resp_router.sv
// Self-checking bench for fabric2_resp_router: directed scenarios plus randomized transactions
// checked against a transaction-level expectation of the routing rules.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE 3'b000
`endif
`ifndef OCP_CMD_WRITE
`define OCP_CMD_WRITE 3'b001
`endif
`ifndef OCP_CMD_READ
`define OCP_CMD_READ 3'b010
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`endif
`ifndef OCP_RESP_DVA
`define OCP_RESP_DVA 2'b01
`endif
`ifndef OCP_RESP_ERR
`define OCP_RESP_ERR 2'b11
`endif

module tb_fabric2_resp_router;

    localparam int unsigned PW  = 11;
    localparam int unsigned NP  = 4;
    localparam int unsigned AW  = `ADDR_WIDTH;
    localparam int unsigned DW  = `DATA_WIDTH;
    localparam int unsigned BW  = `BEN_WIDTH;
    localparam int unsigned RVW = 2 * NP;
    localparam int unsigned DVW = DW * NP;

    localparam logic [2:0] C_IDLE = `OCP_CMD_IDLE;
    localparam logic [2:0] C_WR   = `OCP_CMD_WRITE;
    localparam logic [2:0] C_RD   = `OCP_CMD_READ;
    localparam logic [1:0] R_NULL = `OCP_RESP_NULL;
    localparam logic [1:0] R_DVA  = `OCP_RESP_DVA;
    localparam logic [1:0] R_ERR  = `OCP_RESP_ERR;

    logic               clk;
    logic               rst;
    logic [PW-1:0]      i_portno;
    logic [AW-1:0]      i_addr;
    logic [2:0]         i_MCmd;
    logic [DW-1:0]      i_MData;
    logic [BW-1:0]      i_MByteEn;
    logic               o_SCmdAccept;
    logic [DW-1:0]      o_SData;
    logic [1:0]         o_SResp;
    logic [NP*AW-1:0]   o_MAddr;
    logic [NP*3-1:0]    o_MCmd;
    logic [NP*DW-1:0]   o_MData;
    logic [NP*BW-1:0]   o_MByteEn;
    logic [NP-1:0]      i_SCmdAccept;
    logic [NP*DW-1:0]   i_SData;
    logic [NP*2-1:0]    i_SResp;

    int total = 0;
    int bad   = 0;

    fabric2_resp_router #(
        .PORTNO_WIDTH(PW),
        .NPORTS(NP)
`ifdef FABRIC2_RESP_TIMEOUT_EN
        ,
        .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_portno(i_portno),
        .i_addr(i_addr),
        .i_MCmd(i_MCmd),
        .i_MData(i_MData),
        .i_MByteEn(i_MByteEn),
        .o_SCmdAccept(o_SCmdAccept),
        .o_SData(o_SData),
        .o_SResp(o_SResp),
        .o_MAddr(o_MAddr),
        .o_MCmd(o_MCmd),
        .o_MData(o_MData),
        .o_MByteEn(o_MByteEn),
        .i_SCmdAccept(i_SCmdAccept),
        .i_SData(i_SData),
        .i_SResp(i_SResp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DVW-1:0] rand_data();
        logic [DVW-1:0] v;
        for (int i = 0; i < int'(NP); i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // One transaction from command presentation up to the cycle in which the master sees the
    // response. Returns in that response cycle so the caller may present the next command there.
    task automatic run_txn(input string name, input int port, input logic [2:0] cmd,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [BW-1:0] ben, input int acc_dly, input int rsp_dly,
                           input logic [1:0] srsp, input logic [DW-1:0] sdat,
                           input bit noise, input bit early_rsp);
        logic [2:0]    wc;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [BW-1:0] wb;
        i_portno  = PW'(port);
        i_addr    = addr;
        i_MCmd    = cmd;
        i_MData   = data;
        i_MByteEn = ben;
        #1;
        total++;
        if (o_SCmdAccept !== 1'b1) begin
            bad++;
            $display("FAIL %s accept: got %b want 1", name, o_SCmdAccept);
        end
        step();
        i_MCmd    = C_IDLE;
        i_portno  = PW'($urandom);
        i_addr    = AW'($urandom);
        i_MData   = DW'($urandom);
        if (port >= int'(NP)) begin
            total++;
            if (o_SResp !== R_ERR || o_SData !== '0 || o_MCmd !== {NP{C_IDLE}}) begin
                bad++;
                $display("FAIL %s err_resp: got resp=%b data=%h mcmd=%h want resp=%b data=0 mcmd=0",
                         name, o_SResp, o_SData, o_MCmd, R_ERR);
            end
            step();
            total++;
            if (o_SResp !== R_NULL || o_SData !== '0) begin
                bad++;
                $display("FAIL %s err_one_cycle: got resp=%b data=%h want NULL/0", name, o_SResp, o_SData);
            end
            return;
        end
        for (int c = 0; c <= acc_dly; c++) begin
            for (int k = 0; k < int'(NP); k++) begin
                wc = (k == port) ? cmd  : C_IDLE;
                wa = (k == port) ? addr : '0;
                wd = (k == port) ? data : '0;
                wb = (k == port) ? ben  : '0;
                total++;
                if ({o_MCmd[k*3 +: 3], o_MAddr[k*AW +: AW], o_MData[k*DW +: DW], o_MByteEn[k*BW +: BW]}
                    !== {wc, wa, wd, wb}) begin
                    bad++;
                    $display("FAIL %s slice%0d c%0d: got cmd=%h addr=%h data=%h ben=%h want cmd=%h addr=%h data=%h ben=%h",
                             name, k, c, o_MCmd[k*3 +: 3], o_MAddr[k*AW +: AW], o_MData[k*DW +: DW],
                             o_MByteEn[k*BW +: BW], wc, wa, wd, wb);
                end
            end
            total++;
            if (o_SResp !== R_NULL) begin
                bad++;
                $display("FAIL %s cmd_resp_null: got %b want %b", name, o_SResp, R_NULL);
            end
            i_SCmdAccept = noise ? NP'($urandom) : '0;
            i_SCmdAccept[port] = (c == acc_dly);
            i_SResp = noise ? RVW'($urandom) : '0;
            i_SResp[port*2 +: 2] = (c == acc_dly && early_rsp) ? R_DVA : R_NULL;
            i_SData = rand_data();
            step();
        end
        for (int r = 0; r <= rsp_dly; r++) begin
            total++;
            if (o_MCmd !== {NP{C_IDLE}} || o_SResp !== R_NULL) begin
                bad++;
                $display("FAIL %s resp_wait r%0d: got mcmd=%h resp=%b want 0/NULL", name, r, o_MCmd, o_SResp);
            end
            i_SCmdAccept = noise ? NP'($urandom) : '0;
            i_SCmdAccept[port] = 1'b0;
            i_SResp = noise ? RVW'($urandom) : '0;
            i_SResp[port*2 +: 2] = (r == rsp_dly) ? srsp : R_NULL;
            i_SData = rand_data();
            i_SData[port*DW +: DW] = sdat;
            step();
        end
        i_SCmdAccept = '0;
        i_SResp      = '0;
        i_SData      = '0;
        total++;
        if (o_SResp !== srsp || o_SData !== sdat) begin
            bad++;
            $display("FAIL %s response: got resp=%b data=%h want resp=%b data=%h", name, o_SResp, o_SData, srsp, sdat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_portno = '0; i_addr = '0; i_MCmd = C_IDLE; i_MData = '0; i_MByteEn = '0;
        i_SCmdAccept = '0; i_SData = '0; i_SResp = '0;
        step();
        step();
        total++;
        if (o_SResp !== R_NULL || o_SData !== '0 || o_MCmd !== {NP{C_IDLE}} || o_MAddr !== '0 ||
            o_MData !== '0 || o_MByteEn !== '0 || o_SCmdAccept !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got resp=%b data=%h mcmd=%h addr=%h acc=%b want all zero",
                     o_SResp, o_SData, o_MCmd, o_MAddr, o_SCmdAccept);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_read_port0();
        run_txn("read_p0", 0, C_RD, 32'h0000_1000, 32'h0, 4'hF, 2, 0, R_DVA, 32'hDEAD_BEEF, 1'b0, 1'b0);
        step();
        total++;
        if (o_SResp !== R_NULL || o_SData !== '0) begin
            bad++;
            $display("FAIL read_p0 after: got resp=%b data=%h want NULL/0", o_SResp, o_SData);
        end
    endtask

    task automatic test_write_port2();
        run_txn("write_p2", 2, C_WR, 32'h0000_0004, 32'h1234_5678, 4'hF, 0, 0, R_DVA, 32'h0BAD_F00D, 1'b0, 1'b0);
        step();
        total++;
        if (o_SResp !== R_NULL) begin
            bad++;
            $display("FAIL write_p2 after: got resp=%b want NULL", o_SResp);
        end
    endtask

    task automatic test_unpopulated();
        run_txn("unpop7", 7, C_RD, 32'h40, 32'h0, 4'h0, 0, 0, R_ERR, 32'h0, 1'b0, 1'b0);
        run_txn("unpop4", 4, C_WR, 32'h44, 32'h1, 4'h3, 0, 0, R_ERR, 32'h0, 1'b0, 1'b0);
        run_txn("unpop1025", 1025, C_RD, 32'h48, 32'h0, 4'h1, 0, 0, R_ERR, 32'h0, 1'b0, 1'b0);
        run_txn("unpop2047", 2047, C_RD, 32'h4C, 32'h0, 4'h8, 0, 0, R_ERR, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_p1", 1, C_RD, 32'h0000_0100, 32'h0, 4'hF, 0, 1, R_DVA, 32'h1111_1111, 1'b0, 1'b0);
        run_txn("b2b_p3", 3, C_RD, 32'h0000_0300, 32'h0, 4'hF, 1, 0, R_DVA, 32'h3333_3333, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_early_resp();
        run_txn("early_p2", 2, C_RD, 32'h0000_0200, 32'h0, 4'hC, 1, 1, R_DVA, 32'h2222_2222, 1'b1, 1'b1);
        step();
    endtask

    task automatic test_reset_mid();
        i_portno = PW'(1); i_addr = 32'h0000_0ABC; i_MCmd = C_RD; i_MData = '0; i_MByteEn = 4'hF;
        step();
        i_MCmd = C_IDLE;
        i_SCmdAccept[1] = 1'b1;
        step();
        i_SCmdAccept = '0;
        rst = 1'b1;
        #1;
        total++;
        if (o_SResp !== R_NULL || o_SData !== '0 || o_MCmd !== {NP{C_IDLE}} || o_MAddr !== '0) begin
            bad++;
            $display("FAIL rst_in_resp: got resp=%b data=%h mcmd=%h want zero", o_SResp, o_SData, o_MCmd);
        end
        step();
        rst = 1'b0;
        step();
        i_SResp[1*2 +: 2] = R_DVA;
        i_SData[1*DW +: DW] = 32'hCAFE_0001;
        step();
        i_SResp = '0;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (o_SResp !== R_NULL || o_SData !== '0) begin
                bad++;
                $display("FAIL rst_late_resp c%0d: got resp=%b data=%h want NULL/0", c, o_SResp, o_SData);
            end
            step();
        end
        // Reset while a command is being driven to a slave must drop it at once.
        i_portno = PW'(3); i_addr = 32'h0000_0D00; i_MCmd = C_WR; i_MData = 32'h5555_AAAA; i_MByteEn = 4'h5;
        step();
        i_MCmd = C_IDLE;
        total++;
        if (o_MCmd[3*3 +: 3] !== C_WR) begin
            bad++;
            $display("FAIL rst_cmd_pre: got %h want %h", o_MCmd[3*3 +: 3], C_WR);
        end
        rst = 1'b1;
        #1;
        total++;
        if (o_MCmd !== {NP{C_IDLE}} || o_MAddr !== '0 || o_MData !== '0 || o_MByteEn !== '0) begin
            bad++;
            $display("FAIL rst_in_cmd: got mcmd=%h addr=%h data=%h ben=%h want zero", o_MCmd, o_MAddr, o_MData, o_MByteEn);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_random();
        int port, gap;
        logic [2:0] cmd;
        logic [1:0] srsp;
        for (int n = 0; n < 40; n++) begin
            port = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 2047)) : int'($urandom_range(0, 3));
            cmd  = ($urandom_range(0, 1) == 1) ? C_RD : C_WR;
            srsp = ($urandom_range(0, 4) == 0) ? R_ERR : R_DVA;
            run_txn($sformatf("rand%0d_p%0d", n, port), port, cmd, AW'($urandom), DW'($urandom),
                    BW'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    (port < int'(NP)) ? srsp : R_ERR, (port < int'(NP)) ? DW'($urandom) : '0,
                    1'b1, $urandom_range(0, 1) == 1);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                step();
                total++;
                if (o_SResp !== R_NULL || o_MCmd !== {NP{C_IDLE}}) begin
                    bad++;
                    $display("FAIL rand%0d gap: got resp=%b mcmd=%h want NULL/0", n, o_SResp, o_MCmd);
                end
            end
        end
        step();
    endtask

`ifdef FABRIC2_RESP_TIMEOUT_EN
    task automatic test_timeout();
        i_portno = PW'(1); i_addr = 32'h0000_0010; i_MCmd = C_RD; i_MData = '0; i_MByteEn = 4'hF;
        step();
        i_MCmd = C_IDLE;
        for (int c = 1; c <= 16; c++) begin
            total++;
            if (o_MCmd[1*3 +: 3] !== C_RD || o_SResp !== R_NULL) begin
                bad++;
                $display("FAIL timeout_wait c%0d: got mcmd=%h resp=%b want %h/NULL", c, o_MCmd[1*3 +: 3], o_SResp, C_RD);
            end
            step();
        end
        total++;
        if (o_SResp !== R_ERR || o_SData !== '0 || o_MCmd !== {NP{C_IDLE}}) begin
            bad++;
            $display("FAIL timeout_err: got resp=%b data=%h mcmd=%h want ERR/0/0", o_SResp, o_SData, o_MCmd);
        end
        i_SCmdAccept[1] = 1'b1;
        step();
        i_SCmdAccept = '0;
        i_SResp[1*2 +: 2] = R_DVA;
        step();
        i_SResp = '0;
        for (int c = 0; c < 2; c++) begin
            total++;
            if (o_SResp !== R_NULL) begin
                bad++;
                $display("FAIL timeout_late c%0d: got resp=%b want NULL", c, o_SResp);
            end
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read_port0();
        test_write_port2();
        test_unpopulated();
        test_back_to_back();
        test_early_resp();
        test_reset_mid();
        test_random();
`ifdef FABRIC2_RESP_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
